div_issue_ctrl: RTL and testbench
=================================

# div_issue_ctrl

Issue-side controller for the iterative 64-bit integer divider in the execute stage. Accepts RISC-V DIV/DIVU/REM/REMU and their W variants from issue, drives the divider's request/kill protocol, and captures the one-cycle `done_tick` result. It formats the result (quotient/remainder select, W sign-extension) and holds it for writeback under valid/ready. A one-entry result cache returns the companion DIV/REM of the same operands without re-running the divider.

## Interface
Parameters:
- `TAG_W`, 7: width of the instruction tag (ROB id) carried alongside the op.
- `CACHE_EN`, 1: 1 enables the one-entry result cache; 0 forces every op to the divider.

Ports:
- `clk_i`  in  1  clock. Single clock domain.
- `rst_i`  in  1  reset. Synchronous, active-high.
- `valid_i`  in  1  issue offers an op.
- `ready_o`  out  1  controller can accept.
- `is_rem_i`  in  1  1 = remainder, 0 = quotient.
- `signed_i`  in  1  signed op.
- `int_32_i`  in  1  W variant.
- `rs1_i`  in  64  dividend.
- `rs2_i`  in  64  divisor.
- `tag_i`  in  TAG_W  op tag.
- `flush_i`  in  1  pipeline flush. Kills any in-flight or held op.
- `result_valid_o`  out  1  result available.
- `result_ready_i`  in  1  writeback accepts.
- `result_o`  out  64  formatted result.
- `result_tag_o`  out  TAG_W  tag of result.
- `div_request_o`  out  1  divider `request_i`.
- `div_kill_o`  out  1  divider `kill_div_i`.
- `div_int_32_o`, `div_signed_o`  out  1  divider mode.
- `div_dvnd_o`, `div_dvsr_o`  out  64  divider operands.
- `div_quo_i`, `div_rmd_i`  in  64  divider results. Valid only while `div_done_i` is high.
- `div_stall_i`  in  1  divider busy. Used by assertions only.
- `div_done_i`  in  1  divider `done_tick_o`.

## Operation
- States: IDLE, ISSUE, WAIT, HOLD.
- Accept = `valid_i & ready_o & ~flush_i`. `ready_o = (state==IDLE) & ~rst_i`.
- On accept, register the op fields and tag.
  - Cache hit (`CACHE_EN` set, cache valid, rs1/rs2 all 64 bits equal, signed and int_32 equal): go to HOLD. The result is taken from the cached quotient or remainder.
  - Otherwise go to ISSUE.
- ISSUE: `div_request_o=1` for exactly one cycle, then go to WAIT.
- Divider mode and operand outputs are driven from the registered fields. They stay stable from ISSUE until the cycle after `div_done_i`, because the divider reads its operand inputs again in its done cycle.
- WAIT: on `div_done_i`:
  - select `div_rmd_i` or `div_quo_i` into the result register;
  - write the cache (key plus both raw quotient and remainder, valid=1);
  - go to HOLD.
- Formatting: if int_32, `result_o = {{32{sel[31]}}, sel[31:0]}`; otherwise `sel`. The cache stores unformatted values; formatting is applied on read.
- HOLD: `result_valid_o=1`. `result_o` and `result_tag_o` stay stable until `result_ready_i`. On the handshake, go to IDLE.
- Flush, any state: go to IDLE next cycle, discarding the op/result.
  - In ISSUE or WAIT, `div_kill_o=1` that cycle and `div_request_o=0`.
  - Flush never invalidates the cache, since the cached value is a pure function of the operands.
- Divide-by-zero and signed overflow are resolved by the divider. The controller only selects and sign-extends.

## Timing
- Reset: state IDLE, cache invalid. `ready_o`, `result_valid_o`, `div_request_o`, `div_kill_o` = 0. `result_o`, `result_tag_o`, all `div_*_o` buses = 0.
- Miss latency, accept to `result_valid_o`:
  - 64-bit: accept (cycle 0), ISSUE (1), done at 1+66, HOLD at 68.
  - 32-bit: HOLD at 36.
  - Logic must key off `div_done_i`, never a cycle count.
- Hit latency: `result_valid_o` in the cycle after accept.
- Back-to-back: the earliest next accept is the cycle after the result handshake.
- Flush and `div_done_i` in the same cycle: the result is dropped and the cache is still written.
- Flush while `result_ready_i` is high in HOLD: the handshake is void and no result is delivered.
- Assertions:
  - `div_request_o` only when `~div_stall_i`.
  - `div_done_i` only in WAIT.

## Structure
- A shared package holds:
  - the state enum `div_ctrl_state_t`;
  - constants `DIV_LAT_64=66` and `DIV_LAT_32=34`, for benches and assertions only;
  - the op struct (`is_rem`, `signed`, `int_32`, rs1, rs2, tag).
- Sub-module `div_result_cache`: key compare, storage, hit output, raw quo/rmd read. Instantiated under `generate` when `CACHE_EN` is set.

## Test plan
- DIV signed 64-bit, rs1=-7, rs2=2 -> `div_request_o` one cycle, result 0xFFFFFFFFFFFFFFFD at cycle 68, tag echoed.
- Then REM, same operands -> no request, result 0xFFFFFFFFFFFFFFFF in the next cycle (cache hit).
- DIVUW rs1=0xFFFFFFFF00000064, rs2=7 -> 0x000000000000000E at cycle 36.
- REMW rs1=0x0000000080000000, rs2=0 -> 0xFFFFFFFF80000000.
- DIV 64-bit, flush 20 cycles into WAIT -> `div_kill_o` one cycle, no `result_valid_o`, IDLE next cycle. A following DIVU 100/9 -> 11.
- Backpressure: `result_ready_i` low for 5 cycles in HOLD -> `result_o` and tag stable, `ready_o` low until the handshake. Also reset asserted mid-WAIT -> all outputs 0 and cache invalid.

Source files
------------

// File: rtl/div_issue_ctrl_pkg.sv
// Shared types for the divider issue controller.
// State, cache key, op bundle and result formatting.
package div_issue_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_HOLD
  } div_ctrl_state_t;

  localparam int DIV_LAT_64    = 66;
  localparam int DIV_LAT_32    = 34;
  localparam int DIV_TAG_MAX_W = 16;

  typedef struct packed {
    logic        sgn;
    logic        int_32;
    logic [63:0] rs1;
    logic [63:0] rs2;
  } div_key_t;

  typedef struct packed {
    logic                     is_rem;
    div_key_t                 key;
    logic [DIV_TAG_MAX_W-1:0] tag;
  } div_op_t;

  function automatic logic [63:0] fmt_result(
    input logic [63:0] sel,
    input logic        int_32
  );
    return int_32 ? {{32{sel[31]}}, sel[31:0]} : sel;
  endfunction

endpackage

// File: rtl/div_issue_ctrl_if.sv
// Request/kill/done link between the issue controller
// and the iterative divider.
interface div_issue_ctrl_if;

  logic        div_request_o;
  logic        div_kill_o;
  logic        div_int_32_o;
  logic        div_signed_o;
  logic [63:0] div_dvnd_o;
  logic [63:0] div_dvsr_o;
  logic [63:0] div_quo_i;
  logic [63:0] div_rmd_i;
  logic        div_stall_i;
  logic        div_done_i;

  modport master (
    output div_request_o,
    output div_kill_o,
    output div_int_32_o,
    output div_signed_o,
    output div_dvnd_o,
    output div_dvsr_o,
    input  div_quo_i,
    input  div_rmd_i,
    input  div_stall_i,
    input  div_done_i
  );

  modport slave (
    input  div_request_o,
    input  div_kill_o,
    input  div_int_32_o,
    input  div_signed_o,
    input  div_dvnd_o,
    input  div_dvsr_o,
    output div_quo_i,
    output div_rmd_i,
    output div_stall_i,
    output div_done_i
  );

endinterface

// File: rtl/div_result_cache.sv
// One-entry cache of the last raw quotient/remainder pair,
// keyed by operands and mode.
import div_issue_ctrl_pkg::*;

module div_result_cache (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wr_i,
  input  div_key_t    wr_key_i,
  input  logic [63:0] wr_quo_i,
  input  logic [63:0] wr_rmd_i,
  input  div_key_t    rd_key_i,
  output logic        hit_o,
  output logic [63:0] quo_o,
  output logic [63:0] rmd_o
);

  logic        r_valid;
  div_key_t    r_key;
  logic [63:0] r_quo;
  logic [63:0] r_rmd;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid <= 1'b0;
      r_key   <= '0;
      r_quo   <= '0;
      r_rmd   <= '0;
    end else if (wr_i) begin
      r_valid <= 1'b1;
      r_key   <= wr_key_i;
      r_quo   <= wr_quo_i;
      r_rmd   <= wr_rmd_i;
    end
  end

  assign hit_o = r_valid & (r_key == rd_key_i);
  assign quo_o = r_quo;
  assign rmd_o = r_rmd;

endmodule

// File: rtl/div_issue_ctrl.sv
// Issue-side controller for the iterative 64-bit divider:
// one op in flight, result held for writeback, companion-op cache.
import div_issue_ctrl_pkg::*;

module div_issue_ctrl #(
  parameter int TAG_W    = 7,
  parameter bit CACHE_EN = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic             is_rem_i,
  input  logic             signed_i,
  input  logic             int_32_i,
  input  logic [63:0]      rs1_i,
  input  logic [63:0]      rs2_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             flush_i,
  output logic             result_valid_o,
  input  logic             result_ready_i,
  output logic [63:0]      result_o,
  output logic [TAG_W-1:0] result_tag_o,
  div_issue_ctrl_if.master div
);

  div_ctrl_state_t  r_state;
  div_key_t         r_key;
  logic             r_is_rem;
  logic [TAG_W-1:0] r_tag;
  logic [63:0]      r_sel;

  div_key_t    w_key;
  logic        w_accept;
  logic        w_done;
  logic        w_hit;
  logic        w_busy;
  logic [63:0] w_c_quo;
  logic [63:0] w_c_rmd;

  assign w_key = '{sgn: signed_i, int_32: int_32_i,
                   rs1: rs1_i, rs2: rs2_i};

  assign ready_o  = (r_state == S_IDLE) & ~rst_i;
  assign w_accept = valid_i & ready_o & ~flush_i;
  assign w_done   = (r_state == S_WAIT) & div.div_done_i;
  assign w_busy   = (r_state == S_ISSUE) | (r_state == S_WAIT);

  generate
    if (CACHE_EN) begin : g_cache
      div_result_cache u_cache (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .wr_i     (w_done),
        .wr_key_i (r_key),
        .wr_quo_i (div.div_quo_i),
        .wr_rmd_i (div.div_rmd_i),
        .rd_key_i (w_key),
        .hit_o    (w_hit),
        .quo_o    (w_c_quo),
        .rmd_o    (w_c_rmd)
      );
    end else begin : g_nocache
      assign w_hit   = 1'b0;
      assign w_c_quo = '0;
      assign w_c_rmd = '0;
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_key    <= '0;
      r_is_rem <= 1'b0;
      r_tag    <= '0;
      r_sel    <= '0;
    end else begin
      if (w_accept) begin
        r_key    <= w_key;
        r_is_rem <= is_rem_i;
        r_tag    <= tag_i;
      end
      // raw values are kept; W sign-extension happens on the way out
      if (w_accept & w_hit)
        r_sel <= is_rem_i ? w_c_rmd : w_c_quo;
      else if (w_done)
        r_sel <= r_is_rem ? div.div_rmd_i : div.div_quo_i;
      if (flush_i) begin
        r_state <= S_IDLE;
      end else begin
        unique case (r_state)
          S_IDLE:
            if (w_accept) r_state <= w_hit ? S_HOLD : S_ISSUE;
          S_ISSUE:
            r_state <= S_WAIT;
          S_WAIT:
            if (div.div_done_i) r_state <= S_HOLD;
          S_HOLD:
            if (result_ready_i) r_state <= S_IDLE;
          default:
            r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign result_valid_o = (r_state == S_HOLD);
  assign result_o       = fmt_result(r_sel, r_key.int_32);
  assign result_tag_o   = r_tag;

  assign div.div_request_o = (r_state == S_ISSUE) & ~flush_i & ~rst_i;
  assign div.div_kill_o    = w_busy & flush_i & ~rst_i;
  assign div.div_int_32_o  = r_key.int_32;
  assign div.div_signed_o  = r_key.sgn;
  assign div.div_dvnd_o    = r_key.rs1;
  assign div.div_dvsr_o    = r_key.rs2;

  a_req_not_stalled : assert property (
    @(posedge clk_i) disable iff (rst_i)
    div.div_request_o |-> !div.div_stall_i);

  a_done_in_wait : assert property (
    @(posedge clk_i) disable iff (rst_i)
    div.div_done_i |-> (r_state == S_WAIT));

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl: divider stub, time-based reference
// model with per-cycle compare, and directed operations.
module tb_div_issue_ctrl;
  import div_issue_ctrl_pkg::*;

  localparam int TAG_W = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             valid_i = 1'b0;
  logic             is_rem_i = 1'b0;
  logic             signed_i = 1'b0;
  logic             int_32_i = 1'b0;
  logic [63:0]      rs1_i = '0;
  logic [63:0]      rs2_i = '0;
  logic [TAG_W-1:0] tag_i = '0;
  logic             flush_i = 1'b0;
  logic             result_ready_i = 1'b1;
  logic             ready_o;
  logic             result_valid_o;
  logic [63:0]      result_o;
  logic [TAG_W-1:0] result_tag_o;

  div_issue_ctrl_if dif();

  div_issue_ctrl #(.TAG_W(TAG_W), .CACHE_EN(1'b1)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .valid_i        (valid_i),
    .ready_o        (ready_o),
    .is_rem_i       (is_rem_i),
    .signed_i       (signed_i),
    .int_32_i       (int_32_i),
    .rs1_i          (rs1_i),
    .rs2_i          (rs2_i),
    .tag_i          (tag_i),
    .flush_i        (flush_i),
    .result_valid_o (result_valid_o),
    .result_ready_i (result_ready_i),
    .result_o       (result_o),
    .result_tag_o   (result_tag_o),
    .div            (dif.master)
  );

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int n_req    = 0;

  // RISC-V M-extension semantics, result sign-extended for W ops
  function automatic logic [63:0] rv(input logic rem, input logic sgn,
                                     input logic w,
                                     input logic [63:0] a,
                                     input logic [63:0] b);
    logic [63:0] q, r;
    logic [31:0] a32, b32, q32, r32;
    a32 = a[31:0];
    b32 = b[31:0];
    if (w) begin
      if (b32 == 32'h0) begin q32 = '1; r32 = a32; end
      else if (sgn && a32 == 32'h8000_0000 && b32 == '1) begin
        q32 = a32; r32 = '0;
      end else if (sgn) begin
        q32 = $signed(a32) / $signed(b32);
        r32 = $signed(a32) % $signed(b32);
      end else begin
        q32 = a32 / b32; r32 = a32 % b32;
      end
      q = {{32{q32[31]}}, q32};
      r = {{32{r32[31]}}, r32};
    end else begin
      if (b == 64'h0) begin q = '1; r = a; end
      else if (sgn && a == 64'h8000_0000_0000_0000 && b == '1) begin
        q = a; r = '0;
      end else if (sgn) begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end else begin
        q = a / b; r = a % b;
      end
    end
    return rem ? r : q;
  endfunction

  // divider hands back W results unextended in the low half
  function automatic logic [63:0] raw(input logic rem, input logic sgn,
                                      input logic w,
                                      input logic [63:0] a,
                                      input logic [63:0] b);
    logic [63:0] v;
    v = rv(rem, sgn, w, a, b);
    return w ? {32'h0, v[31:0]} : v;
  endfunction

  logic s_busy = 1'b0;
  int   s_cnt  = 0;

  always @(posedge clk) begin
    if (rst || dif.div_kill_o) s_busy <= 1'b0;
    else if (dif.div_request_o) begin
      s_busy <= 1'b1;
      s_cnt  <= (dif.div_int_32_o ? DIV_LAT_32 : DIV_LAT_64) - 1;
    end else if (s_busy) begin
      if (s_cnt == 0) s_busy <= 1'b0;
      else s_cnt <= s_cnt - 1;
    end
  end

  assign dif.div_stall_i = s_busy;
  assign dif.div_done_i  = s_busy && (s_cnt == 0);
  assign dif.div_quo_i   = dif.div_done_i ?
    raw(1'b0, dif.div_signed_o, dif.div_int_32_o,
        dif.div_dvnd_o, dif.div_dvsr_o) : 64'hDEAD_BEEF_DEAD_BEEF;
  assign dif.div_rmd_i   = dif.div_done_i ?
    raw(1'b1, dif.div_signed_o, dif.div_int_32_o,
        dif.div_dvnd_o, dif.div_dvsr_o) : 64'hBEEF_DEAD_BEEF_DEAD;

  div_op_t     m_op   = '0;
  logic [63:0] m_exp  = '0;
  logic        m_busy = 1'b0;
  logic        m_hit  = 1'b0;
  int          m_rcyc = -1;
  int          m_done = -1;
  int          m_vcyc = -1;
  logic        m_cv   = 1'b0;
  div_key_t    m_ck   = '0;

  // model: an accepted miss requests next cycle and delivers a fixed
  // latency later; a hit delivers next cycle
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      m_busy <= 1'b0;
      m_cv   <= 1'b0;
    end else begin
      if (m_busy && !m_hit && cyc == m_done) begin
        m_cv <= 1'b1;
        m_ck <= m_op.key;
      end
      if (flush_i) m_busy <= 1'b0;
      else if (!m_busy && valid_i) begin
        m_busy <= 1'b1;
        m_op <= '{is_rem: is_rem_i,
                  key: '{sgn: signed_i, int_32: int_32_i,
                         rs1: rs1_i, rs2: rs2_i},
                  tag: DIV_TAG_MAX_W'(tag_i)};
        m_exp <= rv(is_rem_i, signed_i, int_32_i, rs1_i, rs2_i);
        if (m_cv && m_ck.sgn == signed_i && m_ck.int_32 == int_32_i &&
            m_ck.rs1 == rs1_i && m_ck.rs2 == rs2_i) begin
          m_hit  <= 1'b1;
          m_rcyc <= -1;
          m_done <= -1;
          m_vcyc <= cyc + 1;
        end else begin
          m_hit  <= 1'b0;
          m_rcyc <= cyc + 1;
          m_done <= cyc + 1 + (int_32_i ? DIV_LAT_32 : DIV_LAT_64);
          m_vcyc <= cyc + 2 + (int_32_i ? DIV_LAT_32 : DIV_LAT_64);
        end
      end else if (m_busy && cyc >= m_vcyc && result_ready_i)
        m_busy <= 1'b0;
    end
  end

  task automatic chk64(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (dif.div_request_o) n_req <= n_req + 1;
      chk64("ready", 64'(ready_o), 64'(!m_busy));
      chk64("valid", 64'(result_valid_o),
            64'(m_busy && cyc >= m_vcyc));
      chk64("request", 64'(dif.div_request_o),
            64'(m_busy && cyc == m_rcyc && !flush_i));
      chk64("kill", 64'(dif.div_kill_o),
            64'(m_busy && !m_hit && cyc < m_vcyc && flush_i));
      if (m_busy && cyc >= m_vcyc) begin
        chk64("result", result_o, m_exp);
        chk64("tag", 64'(result_tag_o), 64'(m_op.tag));
      end
      if (m_busy && !m_hit && cyc >= m_rcyc && cyc <= m_done) begin
        chk64("dvnd", dif.div_dvnd_o, m_op.key.rs1);
        chk64("dvsr", dif.div_dvsr_o, m_op.key.rs2);
        chk64("mode", {62'h0, dif.div_signed_o, dif.div_int_32_o},
              {62'h0, m_op.key.sgn, m_op.key.int_32});
      end
    end
  end

  task automatic issue(input logic rem, input logic sgn, input logic w,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [TAG_W-1:0] t, output int acc);
    int g = 0;
    while (!ready_o && g < 200) begin
      @(posedge clk); #1; g++;
    end
    chk64("issue_ready", 64'(ready_o), 64'h1);
    is_rem_i = rem; signed_i = sgn; int_32_i = w;
    rs1_i = a; rs2_i = b; tag_i = t;
    valid_i = 1'b1;
    acc = cyc;
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output int at);
    int g = 0;
    while (!result_valid_o && g < budget) begin
      @(posedge clk); #1; g++;
    end
    chk64("valid_timeout", 64'(result_valid_o), 64'h1);
    at = cyc;
  endtask

  task automatic op_check(input string name, input logic rem,
                          input logic sgn, input logic w,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [TAG_W-1:0] t, input int lat,
                          input logic [63:0] res);
    int acc, at, r0;
    r0 = n_req;
    issue(rem, sgn, w, a, b, t, acc);
    wait_valid(100, at);
    chk64({name, "_lat"}, 64'(at - acc), 64'(lat));
    chk64({name, "_res"}, result_o, res);
    chk64({name, "_tag"}, 64'(result_tag_o), 64'(t));
    @(posedge clk); #1;
    chk64({name, "_nreq"}, 64'(n_req - r0), (lat == 1) ? 64'h0 : 64'h1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: no finish by cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  localparam logic [63:0] M7 = 64'hFFFF_FFFF_FFFF_FFF9;
  localparam logic [63:0] M5 = 64'hFFFF_FFFF_FFFF_FFFB;

  initial begin
    int acc, at;
    logic [63:0] hr;
    logic [TAG_W-1:0] ht;

    @(posedge clk);
    @(negedge clk);
    chk64("rst_ready", 64'(ready_o), 64'h0);
    chk64("rst_valid", 64'(result_valid_o), 64'h0);
    chk64("rst_req", 64'(dif.div_request_o), 64'h0);
    chk64("rst_result", result_o, 64'h0);
    chk64("rst_dvnd", dif.div_dvnd_o, 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    op_check("div_s64", 1'b0, 1'b1, 1'b0, M7, 64'd2, 7'h15,
             68, 64'hFFFF_FFFF_FFFF_FFFD);
    op_check("rem_hit", 1'b1, 1'b1, 1'b0, M7, 64'd2, 7'h16,
             1, 64'hFFFF_FFFF_FFFF_FFFF);
    op_check("divuw", 1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_0000_0064,
             64'd7, 7'h20, 36, 64'h0000_0000_0000_000E);
    op_check("remw_z", 1'b1, 1'b1, 1'b1, 64'h0000_0000_8000_0000,
             64'd0, 7'h21, 36, 64'hFFFF_FFFF_8000_0000);

    issue(1'b0, 1'b1, 1'b0, 64'd1000, 64'd3, 7'h22, acc);
    while (cyc < acc + 22) begin @(posedge clk); #1; end
    flush_i = 1'b1;
    @(negedge clk);
    chk64("flush_kill", 64'(dif.div_kill_o), 64'h1);
    @(posedge clk); #1;
    flush_i = 1'b0;
    chk64("flush_idle", 64'(ready_o), 64'h1);
    repeat (60) begin @(posedge clk); #1; end
    chk64("flush_no_valid", 64'(result_valid_o), 64'h0);
    op_check("divu_after_flush", 1'b0, 1'b0, 1'b0, 64'd100, 64'd9,
             7'h23, 68, 64'd11);

    result_ready_i = 1'b0;
    issue(1'b0, 1'b0, 1'b0, 64'd1000, 64'd10, 7'h42, acc);
    wait_valid(100, at);
    hr = result_o;
    ht = result_tag_o;
    chk64("bp_res", hr, 64'd100);
    repeat (5) begin
      @(posedge clk); #1;
      chk64("bp_stable_res", result_o, hr);
      chk64("bp_stable_tag", 64'(result_tag_o), 64'(ht));
      chk64("bp_not_ready", 64'(ready_o), 64'h0);
    end
    result_ready_i = 1'b1;
    @(posedge clk); #1;
    chk64("bp_done_ready", 64'(ready_o), 64'h1);

    issue(1'b0, 1'b1, 1'b0, 64'd77, M5, 7'h25, acc);
    while (cyc < acc + 67) begin @(posedge clk); #1; end
    flush_i = 1'b1;
    @(negedge clk);
    chk64("fd_done", 64'(dif.div_done_i), 64'h1);
    @(posedge clk); #1;
    flush_i = 1'b0;
    chk64("fd_no_valid", 64'(result_valid_o), 64'h0);
    op_check("rem_after_fd", 1'b1, 1'b1, 1'b0, 64'd77, M5, 7'h26,
             1, 64'd2);

    issue(1'b0, 1'b0, 1'b0, 64'd5000, 64'd7, 7'h30, acc);
    repeat (10) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk64("mrst_ready", 64'(ready_o), 64'h0);
    chk64("mrst_valid", 64'(result_valid_o), 64'h0);
    chk64("mrst_kill", 64'(dif.div_kill_o), 64'h0);
    chk64("mrst_result", result_o, 64'h0);
    chk64("mrst_tag", 64'(result_tag_o), 64'h0);
    chk64("mrst_dvnd", dif.div_dvnd_o, 64'h0);
    chk64("mrst_dvsr", dif.div_dvsr_o, 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    op_check("div_after_rst", 1'b0, 1'b1, 1'b0, M7, 64'd2, 7'h27,
             68, 64'hFFFF_FFFF_FFFF_FFFD);

    repeat (3) begin @(posedge clk); #1; end
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
